i2s_unit: RTL
=============

# i2s_unit

I2S transmitter in the `mclk` (`muxclk`) domain of the audioport, at the far end of the synchronizer block. It takes stereo samples delivered as `tick_in` pulses, serializes them into a Philips I2S frame (`sck_out`, `ws_out`, `sdo_out`), and pulses `req_out` once per frame to request the next sample across the domain crossing. The `play_in` control is the synchronized play bit; stopping is frame-aligned.

## Interface
- `SCK_DIV`, default 4: `clk` cycles per `sck_out` period; even, ≥2. Frame = 64·SCK_DIV clk cycles.
- `clk` in 1: single clock (`muxclk`); all logic rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `play_in` in 1: 1 = run, 0 = stop at frame end.
- `tick_in` in 1: one-cycle strobe; audio inputs valid.
- `audio0_in` in 24: left sample, two's complement.
- `audio1_in` in 24: right sample, two's complement.
- `req_out` out 1: one-cycle pulse requesting the next sample.
- `sck_out` out 1: I2S bit clock.
- `ws_out` out 1: word select, 0 = left, 1 = right.
- `sdo_out` out 1: serial data, MSB first.

## Operation
- Input buffer (48 b): loaded with {audio0_in, audio1_in} on every cycle with `tick_in`=1, in any state. Only reset clears it. Multiple ticks per frame: last wins. No tick in a frame: previous sample repeats.
- Counters: `c` 0..SCK_DIV-1 (clk within bit), `s` 0..63 (bit slot). Both wrap together, with `s` advancing when `c` wraps.
- States:
  - IDLE: `c`=`s`=0; all outputs 0.
  - RUN: frame generation.
- IDLE→RUN: `play_in`=1 sampled in IDLE. The first RUN cycle is frame cycle (s=0,c=0).
- Frame start (s=0,c=0, including the first RUN cycle): the shift register loads the input buffer value held before that edge, and `req_out`=1 for exactly that cycle. A `tick_in` coincident with the load edge goes to the buffer for the next frame.
- Slot content:
  - s=0..23: audio0 bits 23..0.
  - s=24..31: 0.
  - s=32..55: audio1 bits 23..0.
  - s=56..63: 0.
- `ws_out`:
  - 1 for s=31..62.
  - 0 for s=63 and s=0..30. It leads each channel MSB by one slot (Philips).
- `sck_out`: 0 for c<SCK_DIV/2, 1 otherwise. `sdo_out`/`ws_out` change only at c=0 (sck falling); the receiver samples on sck rising.
- RUN→IDLE: evaluated only at the last frame cycle (s=63, c=SCK_DIV-1). If `play_in`=0 then, go to IDLE: no load, no `req_out`. Otherwise start the next frame.
  - `play_in` dropping and returning before frame end is invisible.
  - Mid-frame `play_in`=0 never truncates a frame.
- Reset asserted mid-operation: immediate IDLE. All outputs, counters, shift register and buffer go to 0.

## Timing
- All outputs registered; reset value of `req_out`, `sck_out`, `ws_out`, `sdo_out` = 0.
- Start latency: `play_in` high before edge n → at edge n `req_out`=1, `sdo_out`=buffer[47] (audio0 MSB), `ws_out`=0, `sck_out`=0.
- Frame start (frame cycle 0) is measured from edge n. Frame cycle k = s·SCK_DIV+c is the state after edge n+k.
- `req_out` period in steady RUN: exactly 64·SCK_DIV cycles.
- Sample deadline: a `tick_in` arriving at or before edge n+64·SCK_DIV−1 is transmitted in the next frame.
- Stop: last frame ends; the next cycle is IDLE with all outputs 0. A restart is possible one cycle later at the earliest.
- Back-to-back frames: no gap cycles.

## Test plan
- Reset values: hold `rst_n`=0, drive random inputs → all outputs 0. Release with `play_in`=0 → outputs stay 0, `req_out` never pulses.
- Serialization (SCK_DIV=4): tick audio0=24'hABCDEF, audio1=24'h123456, then raise `play_in`:
  - The first frame's slot stream, read on sck rising, equals 0xABCDEF, 8 zeros, 0x123456, 8 zeros.
  - `ws_out` toggles at slots 31 and 63.
  - `sck_out` period is 4 clk.
- Request cadence: continuous play for 10 frames, with a tick 20 cycles after each `req_out` carrying incrementing samples:
  - `req_out` pulses exactly 256 cycles apart.
  - Frame N+1 carries the sample ticked after request N.
- Underrun/overrun:
  - No tick in a frame → the previous sample repeats.
  - Three ticks in one frame → only the last is sent.
  - Tick on the load edge → goes to the following frame.
- Stop/restart:
  - Drop `play_in` at slot 10 → the frame completes through slot 63, no further `req_out`, outputs 0 after.
  - Pulse `play_in` low for slots 10–20 only → no interruption.
- Async reset at slot 40 → all outputs 0 immediately. Run again with SCK_DIV=8 → `req_out` period 512, `sck_out` period 8.

Source files
------------

// File: rtl/i2s_if.sv
// Signal bundle between the audioport synchronizer side and the I2S transmitter.
interface i2s_if;
  logic        play_in;
  logic        tick_in;
  logic [23:0] audio0_in;
  logic [23:0] audio1_in;
  logic        req_out;
  logic        sck_out;
  logic        ws_out;
  logic        sdo_out;

  modport master (
    output play_in, tick_in, audio0_in, audio1_in,
    input  req_out, sck_out, ws_out, sdo_out
  );

  modport slave (
    input  play_in, tick_in, audio0_in, audio1_in,
    output req_out, sck_out, ws_out, sdo_out
  );
endinterface

// File: rtl/i2s_unit.sv
// Philips I2S transmitter: buffers stereo ticks, serializes 64-slot frames and
// requests the next sample once per frame; stopping only takes effect at frame end.
module i2s_unit #(
  parameter int SCK_DIV = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  i2s_if.slave  bus
);
  localparam int              CW     = $clog2(SCK_DIV);
  localparam logic [CW-1:0]   C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   C_ONE  = CW'(1);
  localparam logic [CW-1:0]   C_LAST = CW'(SCK_DIV - 1);
  localparam logic [CW-1:0]   C_HALF = CW'(SCK_DIV / 2);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_c, w_c_nxt;
  logic [5:0]    r_s, w_s_nxt;
  logic [47:0]   r_buf;
  logic [47:0]   r_frame, w_frame_nxt;
  logic          w_load;
  logic          r_req, r_sck, r_ws, r_sdo;

  // Data bit carried in slot s; slots 24..31 and 56..63 are zero padding.
  function automatic logic slot_bit(input logic [47:0] frame, input logic [5:0] s);
    logic b;
    b = 1'b0;
    if (s < 6'd24) begin
      b = frame[6'd47 - s];
    end else if ((s >= 6'd32) && (s < 6'd56)) begin
      b = frame[6'd55 - s];
    end else begin
      b = 1'b0;
    end
    return b;
  endfunction

  // Next-state logic: the stop decision is taken only on the last frame cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_s_nxt     = r_s;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_c_nxt = C_ZERO;
        w_s_nxt = 6'd0;
        if (bus.play_in) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_c == C_LAST) begin
          w_c_nxt = C_ZERO;
          if (r_s == 6'd63) begin
            w_s_nxt = 6'd0;
            if (bus.play_in) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_nxt = r_s + 6'd1;
          end
        end else begin
          w_c_nxt = r_c + C_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_c_nxt     = C_ZERO;
        w_s_nxt     = 6'd0;
      end
    endcase
    w_frame_nxt = w_load ? r_buf : r_frame;
  end

  // State, counters and frame register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_c     <= C_ZERO;
      r_s     <= 6'd0;
      r_frame <= 48'd0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_s     <= w_s_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  // Input buffer: last tick wins; a tick on the load edge lands in the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= 48'd0;
    end else if (bus.tick_in) begin
      r_buf <= {bus.audio0_in, bus.audio1_in};
    end else begin
      r_buf <= r_buf;
    end
  end

  // Outputs are decoded from the next state so they change exactly with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= 1'b0;
      r_sck <= 1'b0;
      r_ws  <= 1'b0;
      r_sdo <= 1'b0;
    end else begin
      r_req <= w_load;
      r_sck <= (w_state_nxt == ST_RUN) && (w_c_nxt >= C_HALF);
      r_ws  <= (w_state_nxt == ST_RUN) && (w_s_nxt >= 6'd31) && (w_s_nxt <= 6'd62);
      r_sdo <= (w_state_nxt == ST_RUN) && slot_bit(w_frame_nxt, w_s_nxt);
    end
  end

  assign bus.req_out = r_req;
  assign bus.sck_out = r_sck;
  assign bus.ws_out  = r_ws;
  assign bus.sdo_out = r_sdo;
endmodule
